// File: rtl/signed_sat_accumulator.sv
// Block accumulator: sums BLOCK_LEN signed samples with per-step saturation and
// hands each block total, plus a sticky clamp flag, to a valid/ready consumer.
module signed_sat_accumulator #(
  parameter int WIDTH     = 4,
  parameter int ACC_WIDTH = 6,
  parameter int BLOCK_LEN = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [WIDTH-1:0]     in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [ACC_WIDTH-1:0] out_sum,
  output logic                        out_sat
);

  localparam int CNT_W = $clog2(BLOCK_LEN + 1);
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(BLOCK_LEN - 1);

  typedef enum logic {ST_ACC, ST_OUT} state_t;

  state_t               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 sat_q, sat_d;
  logic [ACC_WIDTH-1:0] out_sum_q, out_sum_d;
  logic                 out_sat_q, out_sat_d;

  logic [ACC_WIDTH:0]   sum_wide;
  logic [ACC_WIDTH-1:0] acc_step;
  logic                 step_clamped;

  // One guard bit: the top two bits disagree exactly when the step overflowed.
  always_comb begin
    sum_wide     = {acc_q[ACC_WIDTH-1], acc_q}
                 + {{(ACC_WIDTH+1-WIDTH){in_data[WIDTH-1]}}, in_data};
    step_clamped = sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1];
    if (!step_clamped)
      acc_step = sum_wide[ACC_WIDTH-1:0];
    else if (sum_wide[ACC_WIDTH])
      acc_step = ACC_MIN;
    else
      acc_step = ACC_MAX;
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sat_d     = sat_q;
    out_sum_d = out_sum_q;
    out_sat_d = out_sat_q;
    if (clear) begin
      state_d   = ST_ACC;
      acc_d     = '0;
      cnt_d     = '0;
      sat_d     = 1'b0;
      out_sum_d = '0;
      out_sat_d = 1'b0;
    end else begin
      case (state_q)
        ST_ACC: begin
          if (in_valid) begin
            acc_d = acc_step;
            sat_d = sat_q | step_clamped;
            if (cnt_q == CNT_LAST) begin
              cnt_d     = '0;
              state_d   = ST_OUT;
              out_sum_d = acc_step;
              out_sat_d = sat_q | step_clamped;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            state_d   = ST_ACC;
            acc_d     = '0;
            cnt_d     = '0;
            sat_d     = 1'b0;
            out_sum_d = '0;
            out_sat_d = 1'b0;
          end
        end
        default: state_d = ST_ACC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_ACC;
      acc_q     <= '0;
      cnt_q     <= '0;
      sat_q     <= 1'b0;
      out_sum_q <= '0;
      out_sat_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      sat_q     <= sat_d;
      out_sum_q <= out_sum_d;
      out_sat_q <= out_sat_d;
    end
  end

  assign in_ready  = (state_q == ST_ACC);
  assign out_valid = (state_q == ST_OUT);
  assign out_sum   = out_sum_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_signed_sat_accumulator.sv
// Directed bench: instance a uses default widths, instance b uses a 4-bit
// accumulator so clamping is easy to provoke.
module tb_signed_sat_accumulator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr[2];
  logic vld[2];
  logic rdy[2];
  logic signed [3:0] dat[2];
  logic ovld[2];
  logic ordy[2];
  logic osat[2];
  logic signed [5:0] osum_a;
  logic signed [3:0] osum_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  signed_sat_accumulator #(.WIDTH(4), .ACC_WIDTH(6), .BLOCK_LEN(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clr[0]),
    .in_valid(vld[0]), .in_ready(rdy[0]), .in_data(dat[0]),
    .out_valid(ovld[0]), .out_ready(ordy[0]), .out_sum(osum_a), .out_sat(osat[0])
  );

  signed_sat_accumulator #(.WIDTH(4), .ACC_WIDTH(4), .BLOCK_LEN(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clr[1]),
    .in_valid(vld[1]), .in_ready(rdy[1]), .in_data(dat[1]),
    .out_valid(ovld[1]), .out_ready(ordy[1]), .out_sum(osum_b), .out_sat(osat[1])
  );

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one sample and hold it until the DUT takes it (bounded wait).
  task automatic push(input int sel, input int val);
    int n;
    n = 0;
    vld[sel] = 1'b1;
    dat[sel] = val[3:0];
    while (!rdy[sel] && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) chk("push_timeout", 0, 1);
    tick();
    vld[sel] = 1'b0;
  endtask

  task automatic handshake(input int sel);
    int n;
    n = 0;
    ordy[sel] = 1'b1;
    while (!ovld[sel] && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) chk("out_timeout", 0, 1);
    tick();
    ordy[sel] = 1'b0;
    $display("handshake done on instance %0d at %0t", sel, $time);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      clr[i] = 1'b0; vld[i] = 1'b0; dat[i] = '0; ordy[i] = 1'b0;
    end
    #2;
    chk("rst_out_valid", ovld[0], 0);
    chk("rst_in_ready",  rdy[0], 1);
    chk("rst_out_sum",   osum_a, 0);
    chk("rst_out_sat",   osat[0], 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // 1: four max-positive samples fit in 6 bits, out_valid after 4th accept
    push(0, 7); push(0, 7); push(0, 7);
    chk("t1_not_yet_valid", ovld[0], 0);
    push(0, 7);
    chk("t1_out_valid", ovld[0], 1);
    chk("t1_in_ready",  rdy[0], 0);
    chk("t1_sum",       osum_a, 28);
    chk("t1_sat",       osat[0], 0);
    $display("block t1: sum=%0d sat=%0d", osum_a, osat[0]);
    handshake(0);
    chk("t1_after_valid", ovld[0], 0);
    chk("t1_after_ready", rdy[0], 1);
    chk("t1_after_sum",   osum_a, 0);

    // 2: 4,4,-3,1 on 4-bit acc: 4,7(clamp),4,5
    push(1, 4); push(1, 4); push(1, -3); push(1, 1);
    chk("t2_valid", ovld[1], 1);
    chk("t2_sum",   osum_b, 5);
    chk("t2_sat",   osat[1], 1);
    $display("block t2: sum=%0d sat=%0d", osum_b, osat[1]);
    handshake(1);

    // 3: negative rail twice, then a clean block clears the flag
    push(1, -4); push(1, -7); push(1, -1); push(1, 2);
    chk("t3_sum", osum_b, -6);
    chk("t3_sat", osat[1], 1);
    $display("block t3a: sum=%0d sat=%0d", osum_b, osat[1]);
    handshake(1);
    push(1, 1); push(1, 1); push(1, -1); push(1, -1);
    chk("t3b_valid", ovld[1], 1);
    chk("t3b_sum",   osum_b, 0);
    chk("t3b_sat",   osat[1], 0);
    $display("block t3b: sum=%0d sat=%0d", osum_b, osat[1]);
    handshake(1);

    // 4: backpressure with a sample offered that must not be consumed
    push(0, 1); push(0, 2); push(0, 3); push(0, 4);
    vld[0] = 1'b1; dat[0] = 4'sd5;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t4_hold_valid", ovld[0], 1);
      chk("t4_hold_sum",   osum_a, 10);
      chk("t4_hold_ready", rdy[0], 0);
    end
    ordy[0] = 1'b1;
    tick();
    ordy[0] = 1'b0;
    vld[0] = 1'b0;
    chk("t4_post_ready", rdy[0], 1);
    chk("t4_post_valid", ovld[0], 0);
    push(0, 1); push(0, 1); push(0, 1); push(0, 1);
    chk("t4_next_sum", osum_a, 4);
    $display("block t4: sum=%0d sat=%0d", osum_a, osat[0]);
    handshake(0);

    // 5: gaps between samples, then a clear mid-block and one in OUT
    push(0, 7); tick(); tick();
    push(0, -2); tick();
    push(0, 3); tick(); tick(); tick();
    chk("t5_gap_not_valid", ovld[0], 0);
    push(0, 4);
    chk("t5_gap_sum", osum_a, 12);
    chk("t5_gap_sat", osat[0], 0);
    $display("block t5a: sum=%0d sat=%0d", osum_a, osat[0]);
    handshake(0);
    push(0, 3); push(0, 3);
    clr[0] = 1'b1; vld[0] = 1'b1; dat[0] = 4'sd7;
    tick();
    clr[0] = 1'b0; vld[0] = 1'b0;
    push(0, 1); push(0, 2); push(0, 3);
    chk("t5_clr_not_valid", ovld[0], 0);
    push(0, 4);
    chk("t5_clr_valid", ovld[0], 1);
    chk("t5_clr_sum",   osum_a, 10);
    $display("block t5b: sum=%0d sat=%0d", osum_a, osat[0]);
    clr[0] = 1'b1;
    tick();
    clr[0] = 1'b0;
    chk("t5_clr_out_valid", ovld[0], 0);
    chk("t5_clr_out_sum",   osum_a, 0);
    chk("t5_clr_out_ready", rdy[0], 1);

    // 6: asynchronous reset while a result is pending
    push(0, 1); push(0, 2); push(0, 3); push(0, 4);
    chk("t6_pre_valid", ovld[0], 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_valid", ovld[0], 0);
    chk("t6_async_sum",   osum_a, 0);
    chk("t6_async_ready", rdy[0], 1);
    tick();
    rst_n = 1'b1;
    tick();
    push(0, -8); push(0, -8); push(0, -8); push(0, -8);
    chk("t6_fresh_sum", osum_a, -32);
    chk("t6_fresh_sat", osat[0], 0);
    $display("block t6: sum=%0d sat=%0d", osum_a, osat[0]);
    handshake(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
